// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out, ready/data back.
// No latency of its own; the slave holds off a request by keeping imem_ready low.
// The master keeps imem_addr stable for as long as imem_req is high.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH        = 16,
    parameter int INSTRUCTION_WIDTH = 16
) ();
    logic                         imem_req;
    logic [ADDR_WIDTH-1:0]        imem_addr;
    logic                         imem_ready;
    logic [INSTRUCTION_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter plus instruction register, with a variable-latency imem fetch FSM.
// Fetch takes 2 cycles at zero wait (request edge, capture edge); the PC loads on the same edge as its controls.
// Stalls the control FSM via fetch_busy while waiting on imem_ready; flags a sticky error after TIMEOUT waits.
module fetch_unit #(
    parameter int                    INSTRUCTION_WIDTH = 16,
    parameter int                    WIDTH_OPCODE      = 4,
    parameter int                    ADDR_WIDTH        = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC          = 16'h0000,
    parameter int                    PC_INCR           = 2,
    parameter int                    TIMEOUT           = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pc_write,
    input  logic                         pc_write_cond,
    input  logic                         alu_zero,
    input  logic [1:0]                   pc_source,
    input  logic [ADDR_WIDTH-1:0]        alu_result,
    input  logic [ADDR_WIDTH-1:0]        alu_out_buf,
    input  logic                         ir_write,
    fetch_unit_if.master                 imem,
    output logic [ADDR_WIDTH-1:0]        pc,
    output logic [ADDR_WIDTH-1:0]        pc_plus,
    output logic [INSTRUCTION_WIDTH-1:0] instr,
    output logic [WIDTH_OPCODE-1:0]      opcode,
    output logic                         ir_valid,
    output logic                         fetch_busy,
    output logic                         fetch_error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  start;
    logic                  capture;
    logic                  timeout_hit;
    logic [CNT_W-1:0]      wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic                  pc_load;

    // PC datapath: next-value mux and load enable
    assign pc_plus     = pc + ADDR_WIDTH'(PC_INCR);
    assign jump_target = {pc[ADDR_WIDTH-1:12], instr[11:0]};
    assign pc_load     = pc_write | (pc_write_cond & alu_zero);

    always_comb begin
        pc_nxt = RESET_PC;
        case (pc_source)
            2'd0:    pc_nxt = RESET_PC;
            2'd1:    pc_nxt = alu_result;
            2'd2:    pc_nxt = alu_out_buf;
            default: pc_nxt = jump_target;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready on the last permitted wait cycle beats the timeout
    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (ir_write) begin
                    start     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_ready) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ERR;
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            instr       <= '0;
            addr_q      <= '0;
            ir_valid    <= 1'b0;
            fetch_error <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (pc_load) begin
                pc <= pc_nxt;
            end
            ir_valid <= capture;
            // Address latches the PC from before any same-edge load
            if (start) begin
                addr_q   <= pc;
                wait_cnt <= '0;
            end else if (state == WAIT && !imem.imem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (capture) begin
                instr <= imem.imem_rdata;
            end
            if (timeout_hit) begin
                fetch_error <= 1'b1;
            end
        end
    end

    assign imem.imem_req  = (state == WAIT);
    assign imem.imem_addr = addr_q;
    assign fetch_busy     = (state == WAIT);
    assign opcode         = instr[INSTRUCTION_WIDTH-1 -: WIDTH_OPCODE];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected instructions are queued as ready is driven
// and checked when ir_valid pulses; status/PC outputs are checked #1 after each edge.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        pc_write_cond;
    logic        alu_zero;
    logic [1:0]  pc_source;
    logic [15:0] alu_result;
    logic [15:0] alu_out_buf;
    logic        ir_write;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        ir_valid;
    logic        fetch_busy;
    logic        fetch_error;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int busy_cnt;

    logic [15:0] sb[$];

    fetch_unit_if #(.ADDR_WIDTH(16), .INSTRUCTION_WIDTH(16)) imem_if ();

    fetch_unit #(
        .INSTRUCTION_WIDTH(16),
        .WIDTH_OPCODE     (4),
        .ADDR_WIDTH       (16),
        .RESET_PC         (16'h0000),
        .PC_INCR          (2),
        .TIMEOUT          (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .alu_zero     (alu_zero),
        .pc_source    (pc_source),
        .alu_result   (alu_result),
        .alu_out_buf  (alu_out_buf),
        .ir_write     (ir_write),
        .imem         (imem_if),
        .pc           (pc),
        .pc_plus      (pc_plus),
        .instr        (instr),
        .opcode       (opcode),
        .ir_valid     (ir_valid),
        .fetch_busy   (fetch_busy),
        .fetch_error  (fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every ir_valid pulse must match the oldest queued instruction
    always @(negedge clk) begin
        if (reset === 1'b1 && ir_valid === 1'b1) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                chk("sb_instr", {16'h0, instr}, {16'h0, sb.pop_front()});
            end
        end
    end

    initial begin
        reset         = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        alu_zero      = 1'b0;
        pc_source     = 2'd0;
        alu_result    = 16'h0;
        alu_out_buf   = 16'h0;
        ir_write      = 1'b0;
        imem_if.imem_ready = 1'b0;
        imem_if.imem_rdata = 16'h0;
        tick();
        tick();

        // Reset state
        chk("rst_pc", {16'h0, pc}, 32'h0000);
        chk("rst_instr", {16'h0, instr}, 32'h0000);
        chk("rst_opcode", {28'h0, opcode}, 32'h0);
        chk("rst_req", {31'h0, imem_if.imem_req}, 32'h0);
        chk("rst_addr", {16'h0, imem_if.imem_addr}, 32'h0);
        chk("rst_valid", {31'h0, ir_valid}, 32'h0);
        chk("rst_busy", {31'h0, fetch_busy}, 32'h0);
        chk("rst_err", {31'h0, fetch_error}, 32'h0);
        chk("rst_pc_plus", {16'h0, pc_plus}, 32'h0002);
        reset = 1'b1;
        tick();

        // Zero-wait fetch with a same-edge PC load
        ir_write = 1'b1; pc_write = 1'b1; pc_source = 2'd1; alu_result = 16'h0002;
        tick();
        ir_write = 1'b0; pc_write = 1'b0;
        chk("f1_addr", {16'h0, imem_if.imem_addr}, 32'h0000);
        chk("f1_pc", {16'h0, pc}, 32'h0002);
        chk("f1_req", {31'h0, imem_if.imem_req}, 32'h1);
        chk("f1_busy", {31'h0, fetch_busy}, 32'h1);
        imem_if.imem_ready = 1'b1; imem_if.imem_rdata = 16'h1234; sb.push_back(16'h1234);
        tick();
        imem_if.imem_ready = 1'b0;
        chk("f1_instr", {16'h0, instr}, 32'h1234);
        chk("f1_opcode", {28'h0, opcode}, 32'h1);
        chk("f1_valid", {31'h0, ir_valid}, 32'h1);
        chk("f1_busy_done", {31'h0, fetch_busy}, 32'h0);
        chk("f1_req_done", {31'h0, imem_if.imem_req}, 32'h0);
        tick();
        chk("f1_valid_once", {31'h0, ir_valid}, 32'h0);

        // Three-cycle wait, spurious ir_write during WAIT
        ir_write = 1'b1;
        tick();
        ir_write = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (fetch_busy) busy_cnt++;
            chk("f2_addr_stable", {16'h0, imem_if.imem_addr}, 32'h0002);
            ir_write = (i == 0);
            imem_if.imem_ready = (i == 2);
            imem_if.imem_rdata = 16'h5678;
            if (i == 2) sb.push_back(16'h5678);
            tick();
        end
        ir_write = 1'b0; imem_if.imem_ready = 1'b0;
        chk("f2_busy_cycles", busy_cnt, 32'd3);
        chk("f2_instr", {16'h0, instr}, 32'h5678);
        chk("f2_busy_done", {31'h0, fetch_busy}, 32'h0);
        tick();
        chk("f2_no_second_req", {31'h0, imem_if.imem_req}, 32'h0);

        // Conditional branch
        pc_write_cond = 1'b1; pc_source = 2'd2; alu_out_buf = 16'h0040; alu_zero = 1'b0;
        tick();
        chk("br_not_taken", {16'h0, pc}, 32'h0002);
        alu_zero = 1'b1;
        tick();
        pc_write_cond = 1'b0; alu_zero = 1'b0;
        chk("br_taken", {16'h0, pc}, 32'h0040);

        // Jump: fetch 3ABC while loading pc=A010
        ir_write = 1'b1; pc_write = 1'b1; pc_source = 2'd1; alu_result = 16'hA010;
        tick();
        ir_write = 1'b0; pc_write = 1'b0;
        chk("j_addr", {16'h0, imem_if.imem_addr}, 32'h0040);
        imem_if.imem_ready = 1'b1; imem_if.imem_rdata = 16'h3ABC; sb.push_back(16'h3ABC);
        tick();
        imem_if.imem_ready = 1'b0;
        chk("j_pc_pre", {16'h0, pc}, 32'hA010);
        pc_write = 1'b1; pc_source = 2'd3;
        tick();
        chk("j_pc", {16'h0, pc}, 32'hAABC);
        pc_source = 2'd1; alu_result = 16'hFFFE;
        tick();
        chk("wrap_pc_plus", {16'h0, pc_plus}, 32'h0000);
        pc_source = 2'd0;
        tick();
        pc_write = 1'b0;
        chk("src0_reset_vec", {16'h0, pc}, 32'h0000);

        // Ready on the 15th wait cycle wins over the timeout
        ir_write = 1'b1;
        tick();
        ir_write = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("t15_busy", {31'h0, fetch_busy}, 32'h1);
        imem_if.imem_ready = 1'b1; imem_if.imem_rdata = 16'h9ABC; sb.push_back(16'h9ABC);
        tick();
        imem_if.imem_ready = 1'b0;
        chk("t15_no_err", {31'h0, fetch_error}, 32'h0);
        chk("t15_instr", {16'h0, instr}, 32'h9ABC);
        chk("t15_busy_done", {31'h0, fetch_busy}, 32'h0);

        // Full timeout
        ir_write = 1'b1;
        tick();
        ir_write = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("to_pre_err", {31'h0, fetch_error}, 32'h0);
        chk("to_pre_busy", {31'h0, fetch_busy}, 32'h1);
        tick();
        chk("to_err", {31'h0, fetch_error}, 32'h1);
        chk("to_req", {31'h0, imem_if.imem_req}, 32'h0);
        chk("to_busy", {31'h0, fetch_busy}, 32'h0);
        ir_write = 1'b1; imem_if.imem_ready = 1'b1; imem_if.imem_rdata = 16'hBEEF;
        tick();
        tick();
        ir_write = 1'b0; imem_if.imem_ready = 1'b0;
        chk("err_ignore_req", {31'h0, imem_if.imem_req}, 32'h0);
        chk("err_sticky", {31'h0, fetch_error}, 32'h1);
        chk("err_instr_kept", {16'h0, instr}, 32'h9ABC);

        // Reset mid-WAIT
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst_clears_err", {31'h0, fetch_error}, 32'h0);
        pc_write = 1'b1; pc_source = 2'd1; alu_result = 16'h1230;
        tick();
        pc_write = 1'b0;
        ir_write = 1'b1;
        tick();
        ir_write = 1'b0;
        chk("mid_req", {31'h0, imem_if.imem_req}, 32'h1);
        chk("mid_addr", {16'h0, imem_if.imem_addr}, 32'h1230);
        #2 reset = 1'b0;
        #1;
        chk("mid_req_async", {31'h0, imem_if.imem_req}, 32'h0);
        chk("mid_pc", {16'h0, pc}, 32'h0000);
        chk("mid_instr", {16'h0, instr}, 32'h0000);
        chk("mid_busy", {31'h0, fetch_busy}, 32'h0);
        tick();
        reset = 1'b1;
        imem_if.imem_ready = 1'b1; imem_if.imem_rdata = 16'hDEAD;
        tick();
        imem_if.imem_ready = 1'b0;
        chk("late_ready_instr", {16'h0, instr}, 32'h0000);
        chk("late_ready_valid", {31'h0, ir_valid}, 32'h0);
        tick();

        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
